// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 4-register MMIO window
// holding a console TX FIFO, a status word and a cycle counter.
`timescale 1ns/1ps
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        misalign_err,
   output logic [31:0] err_addr
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = FW + 1;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] ram_idx;
   logic [1:0]    sel;
   logic          mmio_hit, aligned, st_ok;
   logic          ram_we, data_we, cyc_we, clr_we;
   logic          fifo_full, fifo_empty, push, pop;

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [7:0]    fifo_d [FIFO_DEPTH];
   logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          misalign_q, misalign_d;
   logic [31:0]   err_addr_q, err_addr_d;
   logic [31:0]   cyc_q, cyc_d;

   // Address decode and store strobes; misaligned stores go nowhere
   always_comb begin
      mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
      sel        = addr[3:2];
      aligned    = (addr[1:0] == 2'b00);
      ram_idx    = addr[AW+1:2];
      st_ok      = we & aligned;
      ram_we     = st_ok & ~mmio_hit;
      data_we    = st_ok & mmio_hit & (sel == 2'd0);
      cyc_we     = st_ok & mmio_hit & (sel == 2'd2);
      clr_we     = st_ok & mmio_hit & (sel == 2'd3);
      fifo_full  = (count_q == CW'(FIFO_DEPTH));
      fifo_empty = (count_q == '0);
      push       = data_we & ~fifo_full;
      pop        = ~fifo_empty & tx_ready;
   end

   // Zero-latency load path; RAM read sees the pre-store contents
   always_comb begin
      rdata = 32'h0;
      if (mmio_hit) begin
         case (sel)
            2'd1:    rdata = {24'h0, 5'(count_q), overflow_q,
                              fifo_full, fifo_empty};
            2'd2:    rdata = cyc_q;
            default: rdata = 32'h0;
         endcase
      end else begin
         rdata = mem[ram_idx];
      end
   end

   // Next-state for FIFO, error capture and cycle counter
   always_comb begin
      fifo_d     = fifo_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      misalign_d = misalign_q;
      err_addr_d = err_addr_q;
      cyc_d      = cyc_we ? 32'h0 : cyc_q + 32'd1;
      if (push) begin
         fifo_d[wr_ptr_q] = wdata[7:0];
         wr_ptr_d         = wr_ptr_q + FW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (clr_we) overflow_d = 1'b0;
      else if (data_we & fifo_full) overflow_d = 1'b1;
      if (we & ~aligned) begin
         misalign_d = 1'b1;
         if (!misalign_q) err_addr_d = addr;
      end else if (clr_we) begin
         misalign_d = 1'b0;
         err_addr_d = 32'h0;
      end
   end

   // Control state registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_q     <= '{default: 8'h0};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         misalign_q <= 1'b0;
         err_addr_q <= 32'h0;
         cyc_q      <= 32'h0;
      end else begin
         fifo_q     <= fifo_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         misalign_q <= misalign_d;
         err_addr_q <= err_addr_d;
         cyc_q      <= cyc_d;
      end
   end

   // RAM array keeps its contents across reset
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_idx] <= wdata;
   end

   assign tx_valid     = ~fifo_empty;
   assign tx_data      = fifo_empty ? 8'h0 : fifo_q[rd_ptr_q];
   assign misalign_err = misalign_q;
   assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, misalign capture,
// console FIFO, cycle counter and asynchronous reset.
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam logic [31:0] MB = 32'hFFFF_0000;
   localparam int DW = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        we = 1'b0;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        misalign_err;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_fail = 0;

   dmem_responder #(
      .DEPTH_WORDS(DW), .MMIO_BASE(MB), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
      .we(we), .rdata(rdata), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .misalign_err(misalign_err), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk);
      #1 we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1 d = rdata;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_tx: valid=%b data=%h want 0/00", tx_valid, tx_data);
      end
      n_checks++;
      if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_err: err=%b addr=%h want 0/0", misalign_err, err_addr);
      end
      rd(MB + 32'h4, v);
      n_checks++;
      if (v !== 32'h1) begin
         n_fail++;
         $display("FAIL reset_status: got %h want 00000001", v);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'd5) begin
         n_fail++;
         $display("FAIL cycle_after_reset: got %0d want 5", v);
      end
   endtask

   task automatic test_ram;
      logic [31:0] v;
      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL ram_load: got %h want deadbeef", v);
      end
      rd(32'h10 + 4 * DW, v);
      n_checks++;
      if (v !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL ram_alias: got %h want deadbeef", v);
      end
      wr(32'h20, 32'h1111_1111);
      @(negedge clk);
      addr = 32'h20; wdata = 32'h2222_2222; we = 1'b1;
      #1;
      n_checks++;
      if (rdata !== 32'h1111_1111) begin
         n_fail++;
         $display("FAIL ram_rbw: got %h want 11111111", rdata);
      end
      @(posedge clk);
      #1 we = 1'b0;
      n_checks++;
      if (rdata !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL ram_after_wr: got %h want 22222222", rdata);
      end
   endtask

   task automatic test_misalign;
      logic [31:0] v;
      wr(32'h13, 32'h1);
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL misalign_suppress: got %h want deadbeef", v);
      end
      n_checks++;
      if (misalign_err !== 1'b1 || err_addr !== 32'h13) begin
         n_fail++;
         $display("FAIL misalign_first: err=%b addr=%h want 1/13", misalign_err, err_addr);
      end
      wr(32'h21, 32'h5);
      n_checks++;
      if (misalign_err !== 1'b1 || err_addr !== 32'h13) begin
         n_fail++;
         $display("FAIL misalign_second: err=%b addr=%h want 1/13", misalign_err, err_addr);
      end
      rd(32'h20, v);
      n_checks++;
      if (v !== 32'h2222_2222) begin
         n_fail++;
         $display("FAIL misalign_ram21: got %h want 22222222", v);
      end
      wr(MB + 32'hC, 32'h0);
      n_checks++;
      if (misalign_err !== 1'b0 || err_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL misalign_clear: err=%b addr=%h want 0/0", misalign_err, err_addr);
      end
   endtask

   task automatic test_console;
      logic [31:0] v;
      logic [7:0]  exp_b;
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_b = 8'h41 + 8'(i);
         wr(MB, {24'h0, exp_b});
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL console_byte%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, exp_b);
         end
      end
      @(posedge clk);
      #1 rd(MB + 32'h4, v);
      n_checks++;
      if (v !== 32'h1 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL console_empty: status=%h valid=%b want 00000001/0", v, tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_overflow;
      logic [31:0] v;
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) wr(MB, i);
      rd(MB + 32'h4, v);
      n_checks++;
      if (v !== 32'h26) begin
         n_fail++;
         $display("FAIL ovf_status: got %h want 00000026", v);
      end
      n_checks++;
      if (tx_data !== 8'h01) begin
         n_fail++;
         $display("FAIL ovf_head: got %h want 01", tx_data);
      end
      @(negedge clk);
      addr = MB; wdata = 32'h6; we = 1'b1; tx_ready = 1'b1;
      @(posedge clk);
      #1 we = 1'b0; tx_ready = 1'b0;
      rd(MB + 32'h4, v);
      n_checks++;
      if (v !== 32'h1C) begin
         n_fail++;
         $display("FAIL ovf_pushpop_status: got %h want 0000001c", v);
      end
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(2 + i)) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, 8'(2 + i));
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_drained: valid=%b want 0", tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_cycle;
      logic [31:0] v;
      @(negedge clk);
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (7) @(posedge clk);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'd7) begin
         n_fail++;
         $display("FAIL cycle_count: got %0d want 7", v);
      end
      wr(MB + 32'h8, 32'h1234);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'd0) begin
         n_fail++;
         $display("FAIL cycle_store: got %0d want 0", v);
      end
      @(posedge clk);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'd1) begin
         n_fail++;
         $display("FAIL cycle_next: got %0d want 1", v);
      end
      @(negedge clk);
      force dut.cyc_q = 32'hFFFF_FFFE;
      #1 release dut.cyc_q;
      @(posedge clk);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL cycle_max: got %h want ffffffff", v);
      end
      @(posedge clk);
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL cycle_wrap: got %h want 00000000", v);
      end
   endtask

   task automatic test_async_reset;
      logic [31:0] v;
      tx_ready = 1'b0;
      wr(MB, 32'h61);
      wr(MB, 32'h62);
      wr(MB, 32'h63);
      wr(32'h13, 32'h7);
      n_checks++;
      if (tx_valid !== 1'b1 || misalign_err !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_setup: valid=%b err=%b want 1/1", tx_valid, misalign_err);
      end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h0 || misalign_err !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_outputs: valid=%b data=%h err=%b want 0/00/0", tx_valid, tx_data, misalign_err);
      end
      rd(MB + 32'h4, v);
      n_checks++;
      if (v !== 32'h1) begin
         n_fail++;
         $display("FAIL arst_status: got %h want 00000001", v);
      end
      rd(MB + 32'h8, v);
      n_checks++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL arst_cycle: got %h want 00000000", v);
      end
      rd(32'h10, v);
      n_checks++;
      if (v !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL arst_ram: got %h want deadbeef", v);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ram();
      test_misalign();
      test_console();
      test_overflow();
      test_cycle();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
